// File: rtl/draw_seq_pkg.sv
// draw_seq_pkg
// Shared definitions for the draw sequencer slice: sequencer state encoding,
// VGA coordinate widths, the default number of draw units and a helper that
// sizes unit-index fields.
// No ports (package).
package draw_seq_pkg;

  localparam int X_W           = 9;
  localparam int Y_W           = 8;
  localparam int NUM_UNITS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_RUN    = 3'd2,
    ST_ACK    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Width of an index into n units; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_sequencer_lowest_set_index.sv
// lowest_set_index
// Combinational priority encoder: reports the index of the lowest set bit of
// vec, so unit 0 always wins when several units are still pending.
// Ports:
//   vec   in  N      request vector
//   idx   out IDX_W  index of the lowest set bit (0 when vec is empty)
//   valid out 1      at least one bit of vec is set
module lowest_set_index
  import draw_seq_pkg::*;
#(
  parameter int N     = NUM_UNITS_DEF,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scanning from the top down lets the lowest set bit overwrite the rest.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer
// Walks the draw units named in unit_mask one at a time (lowest index first)
// on every accepted frame_tick, grants each unit exclusive use of the VGA
// write port while it runs, acknowledges its done flag and finally pulses
// frame_done. All outputs are registered.
// Optional feature: define DRAW_TIMEOUT_EN to bound each unit's RUN time to
// TIMEOUT_CYCLES; a stuck unit is then acked anyway and timeout_err sticks.
// Ports:
//   clock       in  1             system clock, rising edge
//   reset       in  1             synchronous active-low reset
//   frame_tick  in  1             pulse requesting a frame draw
//   unit_mask   in  NUM_UNITS     units to draw, sampled with frame_tick
//   draw_done   in  NUM_UNITS     per-unit done level, held until acked
//   unit_x      in  9*NUM_UNITS   packed per-unit x positions
//   unit_y      in  8*NUM_UNITS   packed per-unit y positions
//   unit_write  in  NUM_UNITS     per-unit VGA write strobes
//   enable      out NUM_UNITS     one-hot-or-zero run grant
//   draw_ack    out NUM_UNITS     one-hot-or-zero one-cycle acknowledge
//   vga_x/vga_y/vga_write out     muxed VGA memory write port
//   busy        out 1             sequencer not idle
//   frame_done  out 1             one-cycle end-of-frame pulse
//   overrun     out 1             one-cycle pulse for a tick dropped while busy
//   timeout_err out 1             sticky unit timeout flag
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int NUM_UNITS      = NUM_UNITS_DEF,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [NUM_UNITS-1:0]     unit_mask,
  input  logic [NUM_UNITS-1:0]     draw_done,
  input  logic [X_W*NUM_UNITS-1:0] unit_x,
  input  logic [Y_W*NUM_UNITS-1:0] unit_y,
  input  logic [NUM_UNITS-1:0]     unit_write,
  output logic [NUM_UNITS-1:0]     enable,
  output logic [NUM_UNITS-1:0]     draw_ack,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic                     vga_write,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun,
  output logic                     timeout_err
);

  localparam int IDX_W = idx_width(NUM_UNITS);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("draw_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  state_e               state_q, state_d;
  logic [NUM_UNITS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [NUM_UNITS-1:0] enable_q, enable_d;
  logic [NUM_UNITS-1:0] draw_ack_q, draw_ack_d;
  logic [X_W-1:0]       vga_x_q, vga_x_d;
  logic [Y_W-1:0]       vga_y_q, vga_y_d;
  logic                 vga_write_q, vga_write_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;

  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_valid;
  logic [X_W-1:0]       cur_x;
  logic [Y_W-1:0]       cur_y;

  lowest_set_index #(
    .N     (NUM_UNITS),
    .IDX_W (IDX_W)
  ) u_lowest (
    .vec   (pending_q),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  assign cur_x = unit_x[int'(cur_q) * X_W +: X_W];
  assign cur_y = unit_y[int'(cur_q) * Y_W +: Y_W];

`ifdef DRAW_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             run_timeout;

  // cnt_q holds the number of RUN cycles already spent by the current unit.
  assign run_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // State and registered-output flops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      cur_q        <= '0;
      enable_q     <= '0;
      draw_ack_q   <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cur_q        <= cur_d;
      enable_q     <= enable_d;
      draw_ack_q   <= draw_ack_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_write_q  <= vga_write_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic; draw_done of units other than cur is never looked at.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cur_d     = cur_q;
`ifdef DRAW_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          pending_d = unit_mask;
          state_d   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_valid) begin
          cur_d   = sel_idx;
          state_d = ST_RUN;
`ifdef DRAW_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_RUN: begin
        if (draw_done[cur_q]) begin
          state_d = ST_ACK;
        end
`ifdef DRAW_TIMEOUT_EN
        else if (run_timeout) begin
          state_d       = ST_ACK;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_ACK: begin
        pending_d[cur_q] = 1'b0;
        state_d          = ST_SELECT;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so that, once registered,
  // they line up with the state they describe.
  // vga_write is only raised when the unit stays in RUN, which keeps it low
  // for the whole ACK cycle that follows a unit's last RUN cycle.
  always_comb begin
    enable_d     = '0;
    draw_ack_d   = '0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_write_d  = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_FINISH);
    overrun_d    = frame_tick && (state_q != ST_IDLE);
    if (state_d == ST_RUN) begin
      enable_d[cur_d] = 1'b1;
    end
    if (state_d == ST_ACK) begin
      draw_ack_d[cur_d] = 1'b1;
    end
    if (state_q == ST_RUN) begin
      vga_x_d     = cur_x;
      vga_y_d     = cur_y;
      vga_write_d = (state_d == ST_RUN) && unit_write[cur_q];
    end
  end

  assign enable     = enable_q;
  assign draw_ack   = draw_ack_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_write  = vga_write_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer
// Scoreboard bench for draw_sequencer. Each scenario pushes the output events
// it expects (kind, data, cycle) into a queue; a negedge monitor pops and
// compares every event the DUT actually produces. A small responder plays
// the draw units: each enabled unit raises draw_done 10 cycles after its
// enable and drops it on draw_ack. When DRAW_TIMEOUT_EN is defined the
// stuck-unit timeout scenario is added.
module tb_draw_sequencer;

  localparam int DONE_DELAY = 10;

  localparam int EV_OVR     = 0;
  localparam int EV_EN      = 1;
  localparam int EV_VGA_ON  = 2;
  localparam int EV_VGA_OFF = 3;
  localparam int EV_TERR    = 4;
  localparam int EV_ACK     = 5;
  localparam int EV_FDONE   = 6;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [3:0]  unit_mask;
  logic [3:0]  draw_done;
  logic [35:0] unit_x;
  logic [31:0] unit_y;
  logic [3:0]  unit_write;
  logic [3:0]  enable;
  logic [3:0]  draw_ack;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic        vga_write;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic        timeout_err;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   t0    = 0;
  ev_t  sb[$];
  logic mon_on = 1'b0;

  logic [3:0] auto_en    = 4'b1111;
  logic [3:0] force_done = 4'b0000;
  logic [3:0] auto_done;
  int         run_cnt[4];

  logic [3:0] prev_enable    = '0;
  logic       prev_vga_write = 1'b0;
  logic       prev_terr      = 1'b0;

  draw_sequencer #(
    .NUM_UNITS      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .unit_mask   (unit_mask),
    .draw_done   (draw_done),
    .unit_x      (unit_x),
    .unit_y      (unit_y),
    .unit_write  (unit_write),
    .enable      (enable),
    .draw_ack    (draw_ack),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_write   (vga_write),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  // Free-running clock and cycle counter.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic string evName(input int k);
    case (k)
      EV_OVR:     return "overrun";
      EV_EN:      return "enable";
      EV_VGA_ON:  return "vga_write_rise";
      EV_VGA_OFF: return "vga_write_fall";
      EV_TERR:    return "timeout_err_rise";
      EV_ACK:     return "draw_ack";
      EV_FDONE:   return "frame_done";
      default:    return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] vgaWord(input logic [8:0] x, input logic [7:0] y);
    return {15'd0, x, y};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExpect(input int kind, input logic [31:0] data, input int at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic seeEvent(input int kind, input logic [31:0] data);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected event: got %s data=0x%0h at cycle %0d, expected nothing",
               evName(kind), data, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.data !== data || e.cyc != cyc) begin
        fails++;
        $display("[TB] FAIL event %s: got %s data=0x%0h cycle %0d, expected %s data=0x%0h cycle %0d",
                 evName(e.kind), evName(kind), data, cyc, evName(e.kind), e.data, e.cyc);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events, in a fixed per-cycle order.
  always @(negedge clock) begin
    if (mon_on) begin
      checkOutput("enable one-hot-or-zero", 32'($onehot0(enable)), 32'd1);
      checkOutput("draw_ack one-hot-or-zero", 32'($onehot0(draw_ack)), 32'd1);
      if (overrun) seeEvent(EV_OVR, 32'd1);
      if (enable != 4'd0 && enable != prev_enable) seeEvent(EV_EN, 32'(enable));
      if (vga_write && !prev_vga_write) seeEvent(EV_VGA_ON, vgaWord(vga_x, vga_y));
      if (!vga_write && prev_vga_write) seeEvent(EV_VGA_OFF, vgaWord(vga_x, vga_y));
      if (timeout_err && !prev_terr) seeEvent(EV_TERR, 32'd1);
      if (draw_ack != 4'd0) seeEvent(EV_ACK, 32'(draw_ack));
      if (frame_done) seeEvent(EV_FDONE, 32'd1);
    end
    prev_enable    <= enable;
    prev_vga_write <= vga_write;
    prev_terr      <= timeout_err;
  end

  // Draw-unit responder: done DONE_DELAY cycles after enable, cleared by ack.
  initial begin
    draw_done = '0;
    auto_done = '0;
    for (int i = 0; i < 4; i++) run_cnt[i] = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        auto_done = '0;
        for (int i = 0; i < 4; i++) run_cnt[i] = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (draw_ack[i]) begin
            auto_done[i] = 1'b0;
            run_cnt[i]   = 0;
          end else if (enable[i]) begin
            run_cnt[i]++;
            if (auto_en[i] && run_cnt[i] == DONE_DELAY + 1) auto_done[i] = 1'b1;
          end
        end
      end
      draw_done = auto_done | force_done;
    end
  end

  task automatic waitCycle(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issues one frame_tick with the given mask; t0 is the tick's cycle.
  task automatic applyStimulus(input logic [3:0] mask);
    frame_tick = 1'b1;
    unit_mask  = mask;
    t0         = cyc;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput({name, " drained in time"}, 32'(n < 200), 32'd1);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    frame_tick = 1'b0;
    unit_mask  = 4'd0;
    unit_write = 4'd0;
    unit_x     = {9'd77, 9'd100, 9'd5, 9'd319};
    unit_y     = {8'd33, 8'd50, 8'd7, 8'd239};

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset enable", 32'(enable), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset vga_write", 32'(vga_write), 32'd0);
    checkOutput("reset timeout_err", 32'(timeout_err), 32'd0);
    reset  = 1'b1;
    mon_on = 1'b1;
    @(posedge clock);
    #1;

    // All four units in order, 13 cycles per unit.
    $display("[TB] scenario: mask 1111");
    applyStimulus(4'b1111);
    checkOutput("busy after accepted tick", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      pushExpect(EV_EN, 32'(4'b0001 << i), t0 + 2 + 13 * i);
      pushExpect(EV_ACK, 32'(4'b0001 << i), t0 + 13 + 13 * i);
    end
    pushExpect(EV_FDONE, 32'd1, t0 + 54);
    waitDrain("mask 1111");

    // Empty mask: straight to FINISH.
    $display("[TB] scenario: mask 0000");
    applyStimulus(4'b0000);
    pushExpect(EV_FDONE, 32'd1, t0 + 2);
    waitDrain("mask 0000");

    // Unit 1 holds done but is not in the mask.
    $display("[TB] scenario: mask 0101 with unit 1 done held");
    force_done = 4'b0010;
    applyStimulus(4'b0101);
    pushExpect(EV_EN, 32'd1, t0 + 2);
    pushExpect(EV_ACK, 32'd1, t0 + 13);
    pushExpect(EV_EN, 32'd4, t0 + 15);
    pushExpect(EV_ACK, 32'd4, t0 + 26);
    pushExpect(EV_FDONE, 32'd1, t0 + 28);
    waitDrain("mask 0101");
    force_done = 4'b0000;

    // Done already high on RUN entry: one RUN cycle only.
    $display("[TB] scenario: done high on RUN entry");
    force_done = 4'b0100;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    applyStimulus(4'b0100);
    pushExpect(EV_EN, 32'd4, t0 + 2);
    pushExpect(EV_ACK, 32'd4, t0 + 3);
    pushExpect(EV_FDONE, 32'd1, t0 + 5);
    waitDrain("early done");
    force_done = 4'b0000;

    // VGA mux: registered copy of the running unit, low in ACK.
    $display("[TB] scenario: vga mux");
    unit_write = 4'b0011;
    applyStimulus(4'b0011);
    pushExpect(EV_EN, 32'd1, t0 + 2);
    pushExpect(EV_VGA_ON, vgaWord(9'd319, 8'd239), t0 + 3);
    pushExpect(EV_VGA_OFF, vgaWord(9'd319, 8'd239), t0 + 13);
    pushExpect(EV_ACK, 32'd1, t0 + 13);
    pushExpect(EV_EN, 32'd2, t0 + 15);
    pushExpect(EV_VGA_ON, vgaWord(9'd5, 8'd7), t0 + 16);
    pushExpect(EV_VGA_OFF, vgaWord(9'd5, 8'd7), t0 + 26);
    pushExpect(EV_ACK, 32'd2, t0 + 26);
    pushExpect(EV_FDONE, 32'd1, t0 + 28);
    waitDrain("vga mux");
    unit_write = 4'b0000;

    // Tick while busy is dropped and flagged.
    $display("[TB] scenario: overrun");
    applyStimulus(4'b0011);
    pushExpect(EV_EN, 32'd1, t0 + 2);
    pushExpect(EV_OVR, 32'd1, t0 + 6);
    pushExpect(EV_ACK, 32'd1, t0 + 13);
    pushExpect(EV_EN, 32'd2, t0 + 15);
    pushExpect(EV_ACK, 32'd2, t0 + 26);
    pushExpect(EV_FDONE, 32'd1, t0 + 28);
    waitCycle(t0 + 5);
    frame_tick = 1'b1;
    unit_mask  = 4'b1111;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
    waitDrain("overrun");

    // Reset during unit 2 RUN.
    $display("[TB] scenario: reset mid-frame");
    applyStimulus(4'b1111);
    pushExpect(EV_EN, 32'd1, t0 + 2);
    pushExpect(EV_ACK, 32'd1, t0 + 13);
    pushExpect(EV_EN, 32'd2, t0 + 15);
    pushExpect(EV_ACK, 32'd2, t0 + 26);
    pushExpect(EV_EN, 32'd4, t0 + 28);
    waitCycle(t0 + 32);
    checkOutput("vga_x before reset", 32'(vga_x), 32'd100);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("mid-frame reset enable", 32'(enable), 32'd0);
    checkOutput("mid-frame reset busy", 32'(busy), 32'd0);
    checkOutput("mid-frame reset draw_ack", 32'(draw_ack), 32'd0);
    checkOutput("mid-frame reset vga_x", 32'(vga_x), 32'd0);
    checkOutput("mid-frame reset vga_y", 32'(vga_y), 32'd0);
    checkOutput("mid-frame reset frame_done", 32'(frame_done), 32'd0);
    reset = 1'b1;
    waitDrain("reset mid-frame");

`ifdef DRAW_TIMEOUT_EN
    // Unit 0 never finishes: timed out after 16 RUN cycles, unit 1 follows.
    $display("[TB] scenario: timeout");
    auto_en = 4'b1110;
    applyStimulus(4'b0011);
    pushExpect(EV_EN, 32'd1, t0 + 2);
    pushExpect(EV_TERR, 32'd1, t0 + 18);
    pushExpect(EV_ACK, 32'd1, t0 + 18);
    pushExpect(EV_EN, 32'd2, t0 + 20);
    pushExpect(EV_ACK, 32'd2, t0 + 31);
    pushExpect(EV_FDONE, 32'd1, t0 + 33);
    waitDrain("timeout");
    checkOutput("timeout_err sticky", 32'(timeout_err), 32'd1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("timeout_err cleared by reset", 32'(timeout_err), 32'd0);
    reset   = 1'b1;
    auto_en = 4'b1111;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
`endif

    checkOutput("scoreboard empty at end", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
